minesweeper_input_ctrl: RTL and testbench

- Sits between the PS/2 key decoder and the Minesweeper board/VGA logic.
- Turns the decoder's one-cycle key pulses into an ordered event stream and buffers it in a small FIFO.
- Sequences the events: cursor moves are applied locally; reveal and clear requests go to the board engine over req/ack handshakes.
- Keys pressed while the board is busy are never lost, up to FIFO capacity.

---
 rtl/minesweeper_pkg.sv | 43 ++++
 rtl/input_event_fifo.sv | 56 +++++
 rtl/minesweeper_input_ctrl.sv | 174 +++++++++++++++++
 tb/tb_minesweeper_input_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared event codes, FSM encoding and board defaults for the Minesweeper input path.
package minesweeper_pkg;

  localparam int DEF_COLS = 8;
  localparam int DEF_ROWS = 8;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_UP     = 3'd1,
    EV_DOWN   = 3'd2,
    EV_LEFT   = 3'd3,
    EV_RIGHT  = 3'd4,
    EV_REVEAL = 3'd5,
    EV_CLEAR  = 3'd6
  } event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_REVEAL,
    ST_CLEAR
  } state_t;

  // Highest-priority pulse wins: clear > reveal > up > down > left > right.
  function automatic event_t encode_event(input logic up, input logic down,
                                          input logic left, input logic right,
                                          input logic reveal, input logic clear);
    if (clear)       return EV_CLEAR;
    else if (reveal) return EV_REVEAL;
    else if (up)     return EV_UP;
    else if (down)   return EV_DOWN;
    else if (left)   return EV_LEFT;
    else if (right)  return EV_RIGHT;
    else             return EV_NONE;
  endfunction

  function automatic logic [2:0] count_pulses(input logic up, input logic down,
                                              input logic left, input logic right,
                                              input logic reveal, input logic clear);
    return 3'(up) + 3'(down) + 3'(left) + 3'(right) + 3'(reveal) + 3'(clear);
  endfunction

endpackage

// File: rtl/input_event_fifo.sv
// Show-ahead FIFO for encoded key events; flush wins over push in the same cycle.
module input_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign data    = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define what is valid, and a resettable array would cost a mux per bit.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state is always written with <= so every reader sees the
  // pre-edge value regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/minesweeper_input_ctrl.sv
// Serialises PS/2 key pulses into an event FIFO and sequences cursor moves,
// reveal requests and board clears toward the board engine.
module minesweeper_input_ctrl
  import minesweeper_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int X_W   = 3,
  parameter int Y_W   = 3,
  parameter int DEPTH = 4,
  parameter int WRAP  = 1
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           key_up,
  input  logic           key_down,
  input  logic           key_left,
  input  logic           key_right,
  input  logic           key_reveal,
  input  logic           key_clear,
  input  logic           game_over,
  input  logic           reveal_ack,
  input  logic           clear_ack,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y,
  output logic           cursor_moved,
  output logic           reveal_req,
  output logic [X_W-1:0] reveal_x,
  output logic [Y_W-1:0] reveal_y,
  output logic           clear_req,
  output logic           busy,
  output logic [7:0]     drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t         state;
  event_t         cur_ev;
  event_t         new_ev;
  logic [2:0]     n_pulses;
  logic [7:0]     drop_inc;
  logic [8:0]     drop_sum;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_flush;
  logic [2:0]     fifo_data;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_full;
  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;

  assign new_ev   = encode_event(key_up, key_down, key_left, key_right, key_reveal, key_clear);
  assign n_pulses = count_pulses(key_up, key_down, key_left, key_right, key_reveal, key_clear);

  // Losers of the priority encode are dropped, and so is the winner when the
  // FIFO was already full before this edge.
  always_comb begin
    drop_inc = '0;
    if (n_pulses != 3'd0)
      drop_inc = {5'd0, n_pulses - 3'd1} + (fifo_full ? 8'd1 : 8'd0);
  end

  assign drop_sum   = {1'b0, drop_cnt} + {1'b0, drop_inc};
  assign fifo_push  = (new_ev != EV_NONE) && !fifo_full;
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign fifo_flush = (state == ST_CLEAR) && clear_req && clear_ack;
  assign busy       = (state != ST_IDLE) || (fifo_count != '0);

  input_event_fifo #(
    .DEPTH (DEPTH),
    .W     (3)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .push_data (new_ev),
    .data      (fifo_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // NOTE: next_x/next_y get their hold value first so no path through the
  // case leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    next_x = cursor_x;
    next_y = cursor_y;
    case (cur_ev)
      EV_UP:
        if (cursor_y == '0) next_y = (WRAP != 0) ? Y_W'(ROWS-1) : cursor_y;
        else                next_y = cursor_y - Y_W'(1);
      EV_DOWN:
        if (cursor_y == Y_W'(ROWS-1)) next_y = (WRAP != 0) ? '0 : cursor_y;
        else                          next_y = cursor_y + Y_W'(1);
      EV_LEFT:
        if (cursor_x == '0) next_x = (WRAP != 0) ? X_W'(COLS-1) : cursor_x;
        else                next_x = cursor_x - X_W'(1);
      EV_RIGHT:
        if (cursor_x == X_W'(COLS-1)) next_x = (WRAP != 0) ? '0 : cursor_x;
        else                          next_x = cursor_x + X_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cur_ev       <= EV_NONE;
      cursor_x     <= '0;
      cursor_y     <= '0;
      cursor_moved <= 1'b0;
      reveal_req   <= 1'b0;
      reveal_x     <= '0;
      reveal_y     <= '0;
      clear_req    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      cursor_moved <= 1'b0;
      drop_cnt     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_ev <= event_t'(fifo_data);
            case (event_t'(fifo_data))
              EV_REVEAL: state <= ST_REVEAL;
              EV_CLEAR:  state <= ST_CLEAR;
              EV_NONE:   state <= ST_IDLE;
              default:   state <= ST_MOVE;
            endcase
          end
        end
        ST_MOVE: begin
          if (!game_over) begin
            cursor_x     <= next_x;
            cursor_y     <= next_y;
            cursor_moved <= (next_x != cursor_x) || (next_y != cursor_y);
          end
          state <= ST_IDLE;
        end
        ST_REVEAL: begin
          // First cycle decides: a finished game discards the reveal outright.
          if (!reveal_req) begin
            if (game_over) begin
              state <= ST_IDLE;
            end else begin
              reveal_x   <= cursor_x;
              reveal_y   <= cursor_y;
              reveal_req <= 1'b1;
            end
          end else if (reveal_ack) begin
            reveal_req <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (!clear_req) begin
            clear_req <= 1'b1;
          end else if (clear_ack) begin
            clear_req    <= 1'b0;
            cursor_x     <= '0;
            cursor_y     <= '0;
            cursor_moved <= (cursor_x != '0) || (cursor_y != '0);
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minesweeper_input_ctrl.sv
// Directed bench: a wrapping and a clamping instance share stimulus and are
// compared every cycle against a queue-based model of the key/event rules.
`timescale 1ns/1ps
module tb_minesweeper_input_ctrl;

  localparam int COLS  = 8;
  localparam int ROWS  = 8;
  localparam int DEPTH = 4;

  // Key vector order: {clear, reveal, up, down, left, right}
  localparam logic [5:0] K_RIGHT = 6'b000001;
  localparam logic [5:0] K_LEFT  = 6'b000010;
  localparam logic [5:0] K_DOWN  = 6'b000100;
  localparam logic [5:0] K_UP    = 6'b001000;
  localparam logic [5:0] K_REV   = 6'b010000;
  localparam logic [5:0] K_CLR   = 6'b100000;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic key_up = 0, key_down = 0, key_left = 0, key_right = 0, key_reveal = 0, key_clear = 0;
  logic game_over = 0, reveal_ack = 0, clear_ack = 0;

  logic [2:0] cx [2];
  logic [2:0] cy [2];
  logic [2:0] rx [2];
  logic [2:0] ry [2];
  logic       moved [2];
  logic       rreq [2];
  logic       creq [2];
  logic       busy [2];
  logic [7:0] dcnt [2];

  always #10 clock = ~clock;

  minesweeper_input_ctrl #(.COLS(COLS), .ROWS(ROWS), .X_W(3), .Y_W(3), .DEPTH(DEPTH), .WRAP(1)) dut_wrap (
    .clock(clock), .resetn(resetn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_reveal(key_reveal), .key_clear(key_clear),
    .game_over(game_over), .reveal_ack(reveal_ack), .clear_ack(clear_ack),
    .cursor_x(cx[0]), .cursor_y(cy[0]), .cursor_moved(moved[0]),
    .reveal_req(rreq[0]), .reveal_x(rx[0]), .reveal_y(ry[0]),
    .clear_req(creq[0]), .busy(busy[0]), .drop_cnt(dcnt[0])
  );

  minesweeper_input_ctrl #(.COLS(COLS), .ROWS(ROWS), .X_W(3), .Y_W(3), .DEPTH(DEPTH), .WRAP(0)) dut_clamp (
    .clock(clock), .resetn(resetn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_reveal(key_reveal), .key_clear(key_clear),
    .game_over(game_over), .reveal_ack(reveal_ack), .clear_ack(clear_ack),
    .cursor_x(cx[1]), .cursor_y(cy[1]), .cursor_moved(moved[1]),
    .reveal_req(rreq[1]), .reveal_x(rx[1]), .reveal_y(ry[1]),
    .clear_req(creq[1]), .busy(busy[1]), .drop_cnt(dcnt[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // job = event currently being worked on (-1 when nothing is in progress).
  typedef struct {
    int job;
    bit started;
    int x, y, rx, ry;
    bit moved, rreq, creq;
    int drops;
  } mdl_t;

  mdl_t m [2];
  int   mq [2][$];
  bit   cmp_en = 0;

  task automatic model_step(input int i);
    bit wrap = (i == 0);
    int n, ev, add, nx, ny;
    bit do_push, flush;
    if (!resetn) begin
      m[i] = '{job:-1, started:0, x:0, y:0, rx:0, ry:0, moved:0, rreq:0, creq:0, drops:0};
      mq[i].delete();
      return;
    end
    n  = int'(key_up) + int'(key_down) + int'(key_left) + int'(key_right) + int'(key_reveal) + int'(key_clear);
    ev = key_clear ? 6 : key_reveal ? 5 : key_up ? 1 : key_down ? 2 : key_left ? 3 : key_right ? 4 : 0;
    do_push = (n > 0) && (mq[i].size() < DEPTH);
    add = (n > 0) ? n - 1 : 0;
    if (n > 0 && mq[i].size() == DEPTH) add++;
    flush = 0;
    m[i].moved = 0;
    if (m[i].job < 0) begin
      if (mq[i].size() > 0) begin
        m[i].job = mq[i].pop_front();
        m[i].started = 0;
      end
    end else if (m[i].job <= 4) begin
      if (!game_over) begin
        nx = m[i].x; ny = m[i].y;
        case (m[i].job)
          1: begin ny = ny - 1; if (ny < 0)     ny = wrap ? ROWS - 1 : 0;        end
          2: begin ny = ny + 1; if (ny == ROWS) ny = wrap ? 0        : ROWS - 1; end
          3: begin nx = nx - 1; if (nx < 0)     nx = wrap ? COLS - 1 : 0;        end
          default: begin nx = nx + 1; if (nx == COLS) nx = wrap ? 0 : COLS - 1; end
        endcase
        m[i].moved = (nx != m[i].x) || (ny != m[i].y);
        m[i].x = nx; m[i].y = ny;
      end
      m[i].job = -1;
    end else if (m[i].job == 5) begin
      if (!m[i].started) begin
        if (game_over) m[i].job = -1;
        else begin
          m[i].rx = m[i].x; m[i].ry = m[i].y; m[i].rreq = 1; m[i].started = 1;
        end
      end else if (reveal_ack) begin
        m[i].rreq = 0; m[i].job = -1;
      end
    end else begin
      if (!m[i].started) begin
        m[i].creq = 1; m[i].started = 1;
      end else if (clear_ack) begin
        m[i].creq = 0;
        m[i].moved = (m[i].x != 0) || (m[i].y != 0);
        m[i].x = 0; m[i].y = 0;
        m[i].job = -1;
        flush = 1;
      end
    end
    if (flush) mq[i].delete();
    else if (do_push) mq[i].push_back(ev);
    m[i].drops = (m[i].drops + add > 255) ? 255 : m[i].drops + add;
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  int moved_cnt [2] = '{0, 0};
  int rreq_cyc = 0;

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cursor_x[%0d]", i), 32'(cx[i]), m[i].x);
        check($sformatf("cursor_y[%0d]", i), 32'(cy[i]), m[i].y);
        check($sformatf("cursor_moved[%0d]", i), 32'(moved[i]), 32'(m[i].moved));
        check($sformatf("reveal_req[%0d]", i), 32'(rreq[i]), 32'(m[i].rreq));
        check($sformatf("reveal_x[%0d]", i), 32'(rx[i]), m[i].rx);
        check($sformatf("reveal_y[%0d]", i), 32'(ry[i]), m[i].ry);
        check($sformatf("clear_req[%0d]", i), 32'(creq[i]), 32'(m[i].creq));
        check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'((m[i].job >= 0) || (mq[i].size() > 0)));
        check($sformatf("drop_cnt[%0d]", i), 32'(dcnt[i]), m[i].drops);
        if (moved[i] === 1'b1) moved_cnt[i]++;
      end
      if (rreq[0] === 1'b1) rreq_cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input logic [5:0] k);
    {key_clear, key_reveal, key_up, key_down, key_left, key_right} = k;
    step();
    {key_clear, key_reveal, key_up, key_down, key_left, key_right} = 6'b0;
  endtask

  task automatic wait_req(input string name, input bit want_clear);
    int t = 0;
    while (((want_clear ? creq[0] : rreq[0]) !== 1'b1) && t < 50) begin
      step();
      t++;
    end
    check(name, 32'(want_clear ? creq[0] : rreq[0]), 1);
  endtask

  task automatic do_clear();
    pulse(K_CLR);
    wait_req("clear_req_rise", 1'b1);
    clear_ack = 1'b1;
    step();
    clear_ack = 1'b0;
  endtask

  int snap0, snap1, snapr;

  initial begin
    // Reset state
    step(3);
    cmp_en = 1'b1;
    check("reset_cursor_x", 32'(cx[0]), 0);
    check("reset_cursor_y", 32'(cy[0]), 0);
    check("reset_busy", 32'(busy[0]), 0);
    check("reset_drop_cnt", 32'(dcnt[0]), 0);
    check("reset_reveal_req", 32'(rreq[0]), 0);
    resetn = 1'b1;
    step(2);

    // Single right press: new cursor after the second edge after sampling
    pulse(K_RIGHT);
    check("lat_x_edge_k", 32'(cx[0]), 0);
    step();
    check("lat_x_edge_k1", 32'(cx[0]), 0);
    step();
    check("lat_x_edge_k2", 32'(cx[0]), 1);
    check("lat_moved_k2", 32'(moved[0]), 1);
    step();
    check("lat_moved_k3", 32'(moved[0]), 0);
    check("lat_busy_done", 32'(busy[0]), 0);

    // Edge behaviour from (0,0): wrap goes to (7,7), clamp stays put silently
    pulse(K_LEFT);
    step(3);
    snap0 = moved_cnt[0];
    snap1 = moved_cnt[1];
    pulse(K_LEFT);
    pulse(K_UP);
    step(6);
    check("wrap_x", 32'(cx[0]), 7);
    check("wrap_y", 32'(cy[0]), 7);
    check("clamp_x", 32'(cx[1]), 0);
    check("clamp_y", 32'(cy[1]), 0);
    check("wrap_moved_pulses", 32'(moved_cnt[0] - snap0), 2);
    check("clamp_moved_pulses", 32'(moved_cnt[1] - snap1), 0);

    // Reach (3,5), then hold a reveal for 20 cycles while three rights queue
    do_clear();
    check("clear_home_x", 32'(cx[0]), 0);
    check("clear_home_y", 32'(cy[0]), 0);
    for (int i = 0; i < 3; i++) begin pulse(K_RIGHT); step(); end
    for (int i = 0; i < 5; i++) begin pulse(K_DOWN); step(); end
    step(4);
    check("pos_x_3", 32'(cx[0]), 3);
    check("pos_y_5", 32'(cy[0]), 5);
    pulse(K_REV);
    wait_req("reveal_req_rise", 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c == 2 || c == 8 || c == 14) key_right = 1'b1;
      step();
      key_right = 1'b0;
      check("hold_reveal_req", 32'(rreq[0]), 1);
      check("hold_reveal_x", 32'(rx[0]), 3);
      check("hold_reveal_y", 32'(ry[0]), 5);
      check("hold_cursor_x", 32'(cx[0]), 3);
    end
    reveal_ack = 1'b1;
    step();
    reveal_ack = 1'b0;
    check("reveal_req_after_ack", 32'(rreq[0]), 0);
    step(10);
    check("queued_rights_x", 32'(cx[0]), 6);
    check("queued_rights_x_clamp", 32'(cx[1]), 6);

    // Same-cycle up + reveal: reveal wins, up is dropped
    pulse(K_UP | K_REV);
    check("collide_drop_cnt", 32'(dcnt[0]), 1);
    wait_req("collide_reveal_req", 1'b0);
    reveal_ack = 1'b1;
    step();
    reveal_ack = 1'b0;
    step(5);
    check("collide_y_unchanged", 32'(cy[0]), 5);

    // Six moves during a held reveal: four fit, two dropped (running total 3)
    pulse(K_REV);
    wait_req("overflow_reveal_req", 1'b0);
    for (int i = 0; i < 6; i++) begin pulse(K_RIGHT); step(); end
    check("overflow_drop_cnt", 32'(dcnt[0]), 3);
    reveal_ack = 1'b1;
    step();
    reveal_ack = 1'b0;
    step(15);
    check("overflow_x_wrap", 32'(cx[0]), 2);
    check("overflow_x_clamp", 32'(cx[1]), 7);

    // Game over blocks moves and reveals but not clear
    game_over = 1'b1;
    snapr = rreq_cyc;
    pulse(K_DOWN);
    step();
    pulse(K_REV);
    step(8);
    check("go_y_blocked", 32'(cy[0]), 5);
    check("go_no_reveal", 32'(rreq_cyc - snapr), 0);
    check("go_idle", 32'(busy[0]), 0);
    do_clear();
    check("go_clear_x", 32'(cx[0]), 0);
    check("go_clear_y", 32'(cy[0]), 0);
    check("go_clear_busy", 32'(busy[0]), 0);
    game_over = 1'b0;
    step(2);

    // Reset during an outstanding reveal
    pulse(K_RIGHT);
    pulse(K_DOWN);
    step(5);
    pulse(K_REV);
    wait_req("rst_reveal_req", 1'b0);
    resetn = 1'b0;
    step();
    check("rst_reveal_req", 32'(rreq[0]), 0);
    check("rst_cursor_x", 32'(cx[0]), 0);
    check("rst_cursor_y", 32'(cy[0]), 0);
    check("rst_drop_cnt", 32'(dcnt[0]), 0);
    resetn = 1'b1;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
